// File: rtl/segasys1_pkg.sv
// Shared definitions for the SEGASYSTEM1 high-score port: sequencer states and
// the address page that the top-level decode routes to main RAM.
package segasys1_pkg;

  typedef enum logic [2:0] {
    HS_IDLE    = 3'd0,
    HS_SETTLE  = 3'd1,
    HS_RD_WAIT = 3'd2,
    HS_RD_PUSH = 3'd3,
    HS_WR_DATA = 3'd4,
    HS_WR_STB  = 3'd5,
    HS_DONE    = 3'd6
  } hs_state_t;

  localparam logic [3:0] HS_MAIN_PAGE = 4'hC;

  // 0xCxxx is main RAM, everything else is video RAM.
  function automatic logic hs_is_main(input logic [15:0] addr);
    return addr[15:12] == HS_MAIN_PAGE;
  endfunction

endpackage

// File: rtl/segasys1_hs_addrgen.sv
// Address and remaining-byte counters for one high-score block transfer.
// The address wraps 0xFFFF -> 0x0000; o_last marks the final byte.
module segasys1_hs_addrgen
  import segasys1_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [15:0]      i_base,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_advance,
  output logic [15:0]      o_addr,
  output logic             o_last
);

  logic [15:0]      r_addr;
  logic [LEN_W-1:0] r_remaining;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (i_load) begin
      r_addr      <= i_base;
      r_remaining <= i_len;
    end else if (i_advance) begin
      r_addr      <= r_addr + 16'd1;
      r_remaining <= r_remaining - LEN_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_remaining == LEN_W'(1));

endmodule

// File: rtl/segasys1_hs_sequencer.sv
// Sequences dump (RAM->host) and load (host->RAM) block transfers over the
// shared HSAD/HSDO/HSDI/HSWE port, pausing the core for the whole transfer.
module segasys1_hs_sequencer
  import segasys1_pkg::*;
#(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned LEN_W  = 16
) (
  input  logic             clk40M,
  input  logic             reset,
  input  logic             start_dump,
  input  logic             start_load,
  input  logic             abort,
  input  logic [15:0]      base,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             pause_req,
  input  logic [7:0]       ld_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  output logic [7:0]       dump_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [15:0]      HSAD,
  output logic [7:0]       HSDI,
  output logic             HSWE,
  input  logic [7:0]       HSDO
);

  hs_state_t   r_state;
  logic [7:0]  r_cnt;
  logic        r_dir_load;
  logic        r_aborted;
  logic        r_zero_done;
  logic [7:0]  r_dump_data;
  logic [7:0]  r_hsdi;

  logic        w_start;
  logic        w_accept;
  logic        w_load;
  logic        w_advance;
  logic        w_last;
  logic        w_active;
  logic [15:0] w_addr;

  assign w_start   = start_dump | start_load;
  assign w_accept  = (r_state == HS_IDLE) & w_start;
  assign w_load    = w_accept & (len != '0);
  assign w_active  = (r_state != HS_IDLE) & (r_state != HS_DONE);
  assign w_advance = ((r_state == HS_RD_PUSH) & dump_ready & ~abort) |
                     (r_state == HS_WR_STB);

  segasys1_hs_addrgen #(
    .LEN_W(LEN_W)
  ) u_addrgen (
    .clk      (clk40M),
    .reset    (reset),
    .i_load   (w_load),
    .i_base   (base),
    .i_len    (len),
    .i_advance(w_advance),
    .o_addr   (w_addr),
    .o_last   (w_last)
  );

  // HSWE decodes WR_STB directly, so an abort landing on the strobe cycle
  // still completes that byte; the handshake outputs are masked by abort.
  always_ff @(posedge clk40M) begin
    if (reset) begin
      r_state     <= HS_IDLE;
      r_cnt       <= '0;
      r_dir_load  <= 1'b0;
      r_aborted   <= 1'b0;
      r_zero_done <= 1'b0;
      r_dump_data <= '0;
      r_hsdi      <= '0;
    end else begin
      r_zero_done <= 1'b0;
      if (abort && w_active) begin
        r_state   <= HS_DONE;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          HS_IDLE: begin
            if (w_accept) begin
              r_aborted <= 1'b0;
              if (len == '0) begin
                r_zero_done <= 1'b1;
              end else begin
                r_dir_load <= ~start_dump;
                r_cnt      <= '0;
                r_state    <= HS_SETTLE;
              end
            end
          end
          HS_SETTLE: begin
            if (r_cnt == 8'(SETTLE - 1)) begin
              r_cnt   <= '0;
              r_state <= r_dir_load ? HS_WR_DATA : HS_RD_WAIT;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          HS_RD_WAIT: begin
            if (r_cnt == 8'(RD_LAT)) begin
              r_cnt       <= '0;
              r_dump_data <= HSDO;
              r_state     <= HS_RD_PUSH;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          HS_RD_PUSH: begin
            if (dump_ready) begin
              r_state <= w_last ? HS_DONE : HS_RD_WAIT;
            end
          end
          HS_WR_DATA: begin
            if (ld_valid) begin
              r_hsdi  <= ld_data;
              r_state <= HS_WR_STB;
            end
          end
          HS_WR_STB: begin
            r_state <= w_last ? HS_DONE : HS_WR_DATA;
          end
          HS_DONE: begin
            r_state <= HS_IDLE;
          end
          default: begin
            r_state <= HS_IDLE;
          end
        endcase
      end
    end
  end

  assign busy       = (r_state != HS_IDLE);
  assign pause_req  = (r_state != HS_IDLE);
  assign done       = (r_state == HS_DONE) | r_zero_done;
  assign aborted    = (r_state == HS_DONE) & r_aborted;
  assign dump_valid = (r_state == HS_RD_PUSH) & ~abort;
  assign ld_ready   = (r_state == HS_WR_DATA) & ~abort;
  assign dump_data  = r_dump_data;
  assign HSDI       = r_hsdi;
  assign HSWE       = (r_state == HS_WR_STB);
  assign HSAD       = w_addr;

endmodule

// File: tb/tb_segasys1_hs_sequencer.sv
// Scoreboard bench for segasys1_hs_sequencer: stimulus pushes expected bytes,
// writes and done events; a negedge monitor pops and compares them.
module tb_segasys1_hs_sequencer;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned LEN_W  = 16;

  logic        clk40M = 1'b0;
  logic        reset = 1'b1;
  logic        start_dump = 1'b0, start_load = 1'b0, abort = 1'b0;
  logic [15:0] base = '0;
  logic [15:0] len = '0;
  logic        busy, done, aborted, pause_req;
  logic [7:0]  ld_data;
  logic        ld_valid, ld_ready;
  logic [7:0]  dump_data;
  logic        dump_valid, dump_ready;
  logic [15:0] HSAD;
  logic [7:0]  HSDI;
  logic        HSWE;
  logic [7:0]  HSDO;

  always #5 clk40M = ~clk40M;

  segasys1_hs_sequencer #(
    .RD_LAT(RD_LAT),
    .SETTLE(SETTLE),
    .LEN_W (LEN_W)
  ) dut (
    .clk40M    (clk40M),
    .reset     (reset),
    .start_dump(start_dump),
    .start_load(start_load),
    .abort     (abort),
    .base      (base),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .pause_req (pause_req),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .dump_data (dump_data),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .HSAD      (HSAD),
    .HSDI      (HSDI),
    .HSWE      (HSWE),
    .HSDO      (HSDO)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        last;
  } xfer_t;

  typedef struct {
    logic [7:0]  d;
    int unsigned gap;
  } ld_item_t;

  xfer_t    exp_dump[$];
  xfer_t    exp_wr[$];
  logic     exp_done[$];
  ld_item_t ld_plan[$];
  ld_item_t ld_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int rdy_mode = 0;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [7:0] p1;

  // Port memory: two registered stages from HSAD to HSDO (RD_LAT = 2).
  always @(posedge clk40M) begin
    HSDO <= p1;
    p1   <= mem[HSAD];
    if (HSWE) mem[HSAD] = HSDI;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h with nothing expected (t=%0t)", name, act, $time);
  endtask

  task automatic cyc();
    @(posedge clk40M);
    #1;
  endtask

  // Reference model: a dump returns the model memory contents in address order
  // (16-bit wrap); a load writes the host bytes in order; every start ends in done.
  task automatic start_xfer(input bit sd, input bit sl, input logic [15:0] b,
                            input logic [15:0] n, input bit exp_abort);
    xfer_t       e;
    logic [15:0] a;
    if (sd || sl) begin
      if (n == 16'd0) begin
        exp_done.push_back(1'b0);
      end else if (sd) begin
        for (int i = 0; i < int'(n); i++) begin
          a = b + 16'(i);
          e.addr = a;
          e.data = ref_mem[a];
          e.last = (i == int'(n) - 1);
          exp_dump.push_back(e);
        end
        exp_done.push_back(exp_abort);
      end else begin
        for (int i = 0; i < int'(n) && i < ld_plan.size(); i++) begin
          a = b + 16'(i);
          e.addr = a;
          e.data = ld_plan[i].d;
          e.last = !exp_abort && (i == int'(n) - 1);
          exp_wr.push_back(e);
          ref_mem[a] = ld_plan[i].d;
          ld_q.push_back(ld_plan[i]);
        end
        exp_done.push_back(exp_abort);
      end
    end
    ld_plan.delete();
    cyc();
    start_dump = sd;
    start_load = sl;
    base = b;
    len  = n;
    cyc();
    start_dump = 1'b0;
    start_load = 1'b0;
    base = 16'($urandom);
    len  = 16'($urandom);
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk40M);
      k++;
    end while ((busy || exp_dump.size() != 0 || exp_wr.size() != 0 || exp_done.size() != 0) && k < 5000);
    if (k >= 5000) fail_evt("wait_idle_timeout", 32'(busy));
    repeat (2) @(posedge clk40M);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_pause_req"}, pause_req, 0);
    chk({tag, "_ld_ready"}, ld_ready, 0);
    chk({tag, "_dump_valid"}, dump_valid, 0);
    chk({tag, "_dump_data"}, dump_data, 0);
    chk({tag, "_HSAD"}, HSAD, 0);
    chk({tag, "_HSDI"}, HSDI, 0);
    chk({tag, "_HSWE"}, HSWE, 0);
  endtask

  // Load host: presents queued bytes after their gap, holds until consumed.
  initial begin
    ld_item_t it;
    int k;
    ld_valid = 1'b0;
    ld_data  = '0;
    forever begin
      cyc();
      if (ld_q.size() != 0) begin
        it = ld_q.pop_front();
        repeat (it.gap) cyc();
        ld_data  = it.d;
        ld_valid = 1'b1;
        k = 0;
        @(negedge clk40M);
        while (!ld_ready && k < 5000) begin
          @(negedge clk40M);
          k++;
        end
        if (k >= 5000) fail_evt("ld_handshake_timeout", 32'(ld_valid));
        cyc();
        ld_valid = 1'b0;
        ld_data  = 8'($urandom);
      end
    end
  end

  // Dump host: 0 = always ready, 1 = random stalls, 2 = never ready.
  initial begin
    dump_ready = 1'b0;
    forever begin
      cyc();
      case (rdy_mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = ($urandom_range(0, 3) != 0);
        default: dump_ready = 1'b0;
      endcase
    end
  end

  logic  chk_done_next  = 1'b0;
  logic  chk_pause_next = 1'b0;
  logic  prev_hswe      = 1'b0;
  xfer_t me;
  logic  mexp;

  always @(negedge clk40M) begin
    if (reset) begin
      chk_done_next  = 1'b0;
      chk_pause_next = 1'b0;
      prev_hswe      = 1'b0;
    end else begin
      if (chk_done_next) begin
        chk("done_after_last_byte", done, 1);
        chk_done_next = 1'b0;
      end
      if (chk_pause_next) begin
        chk("pause_req_after_done", pause_req, 0);
        chk_pause_next = 1'b0;
      end
      if (dump_valid && dump_ready) begin
        if (exp_dump.size() == 0) fail_evt("unexpected_dump_byte", dump_data);
        else begin
          me = exp_dump.pop_front();
          chk("dump_HSAD", HSAD, me.addr);
          chk("dump_data", dump_data, me.data);
          if (me.last) chk_done_next = 1'b1;
        end
      end
      if (HSWE) begin
        wr_count++;
        chk("hswe_single_cycle", prev_hswe, 0);
        if (exp_wr.size() == 0) fail_evt("unexpected_write", HSAD);
        else begin
          me = exp_wr.pop_front();
          chk("write_HSAD", HSAD, me.addr);
          chk("write_HSDI", HSDI, me.data);
          if (me.last) chk_done_next = 1'b1;
        end
      end
      prev_hswe = HSWE;
      if (ld_ready) chk("ld_ready_qualifiers", {pause_req, HSWE}, 2'b10);
      if (done) begin
        if (exp_done.size() == 0) fail_evt("unexpected_done", aborted);
        else begin
          mexp = exp_done.pop_front();
          chk("done_aborted_flag", aborted, mexp);
        end
        chk_pause_next = 1'b1;
      end else if (aborted) begin
        fail_evt("aborted_without_done", aborted);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not reach its end (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int          lat;
    int          k;
    int          w0;
    bit          d;
    logic [15:0] b;
    logic [15:0] n;
    ld_item_t    li;

    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clk40M);
    check_all_zero("reset");

    // 1: dump C000 len 3, always ready
    mem[16'hC000] = 8'h11; ref_mem[16'hC000] = 8'h11;
    mem[16'hC001] = 8'h22; ref_mem[16'hC001] = 8'h22;
    mem[16'hC002] = 8'h33; ref_mem[16'hC002] = 8'h33;
    rdy_mode = 0;
    start_xfer(1, 0, 16'hC000, 16'd3, 0);
    @(negedge clk40M);
    chk("t1_pause_rises", pause_req, 1);
    chk("t1_busy", busy, 1);
    lat = 1;
    while (!dump_valid && lat < 100) begin
      @(negedge clk40M);
      lat++;
    end
    chk("t1_first_byte_not_early", 32'(lat >= int'(SETTLE + RD_LAT + 1)), 1);
    chk("t1_first_byte_not_late", 32'(lat < 20), 1);
    wait_idle();
    chk("t1_idle_pause", pause_req, 0);

    // 2: load D800 len 2, AA then BB after a 5-cycle gap
    li.d = 8'hAA; li.gap = 0; ld_plan.push_back(li);
    li.d = 8'hBB; li.gap = 5; ld_plan.push_back(li);
    w0 = wr_count;
    start_xfer(0, 1, 16'hD800, 16'd2, 0);
    wait_idle();
    chk("t2_write_count", wr_count - w0, 2);

    // 3: dump across the address wrap
    rdy_mode = 1;
    start_xfer(1, 0, 16'hFFFF, 16'd2, 0);
    wait_idle();

    // 4: simultaneous starts, then a start_load while busy
    w0 = wr_count;
    start_xfer(1, 1, 16'h8123, 16'd1, 0);
    repeat (2) cyc();
    start_load = 1'b1; base = 16'h4000; len = 16'd3;
    cyc();
    start_load = 1'b0;
    wait_idle();
    chk("t4_no_writes", wr_count - w0, 0);
    chk("t4_idle_after", busy, 0);

    // 5: load len 4, abort after the second write
    li.d = 8'h5A; li.gap = 0; ld_plan.push_back(li);
    li.d = 8'hC3; li.gap = 1; ld_plan.push_back(li);
    w0 = wr_count;
    start_xfer(0, 1, 16'h1230, 16'd4, 1);
    k = 0;
    while (wr_count < w0 + 2 && k < 2000) begin
      @(negedge clk40M);
      k++;
    end
    if (k >= 2000) fail_evt("t5_second_write_timeout", 32'(wr_count - w0));
    cyc();
    abort = 1'b1;
    @(negedge clk40M);
    chk("t5_ld_ready_in_abort", ld_ready, 0);
    chk("t5_hswe_in_abort", HSWE, 0);
    cyc();
    abort = 1'b0;
    @(negedge clk40M);
    chk("t5_done", done, 1);
    chk("t5_aborted", aborted, 1);
    wait_idle();
    chk("t5_write_count", wr_count - w0, 2);

    // abort in IDLE has no effect
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    @(negedge clk40M);
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_done", done, 0);

    // 6a: zero-length start
    start_xfer(1, 0, 16'h2000, 16'd0, 0);
    @(negedge clk40M);
    chk("t6_zero_done", done, 1);
    chk("t6_zero_pause", pause_req, 0);
    chk("t6_zero_busy", busy, 0);
    @(negedge clk40M);
    chk("t6_zero_done_once", done, 0);
    chk("t6_zero_pause_after", pause_req, 0);
    wait_idle();

    // 6b: reset while a dump byte is waiting for the host
    rdy_mode = 2;
    start_xfer(1, 0, 16'hC010, 16'd3, 0);
    k = 0;
    while (!dump_valid && k < 200) begin
      @(negedge clk40M);
      k++;
    end
    chk("t6_reached_push", dump_valid, 1);
    cyc();
    reset = 1'b1;
    exp_dump.delete();
    exp_done.delete();
    cyc();
    reset = 1'b0;
    @(negedge clk40M);
    check_all_zero("t6_midreset");
    repeat (4) @(negedge clk40M);
    chk("t6_no_done_after_reset", done, 0);
    rdy_mode = 1;

    // randomized transfers
    for (int t = 0; t < 30; t++) begin
      d = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) b = 16'hFFFC + 16'($urandom_range(0, 3));
      else b = 16'($urandom);
      n = 16'($urandom_range(0, 5));
      if (!d) begin
        for (int i = 0; i < int'(n); i++) begin
          li.d   = 8'($urandom);
          li.gap = $urandom_range(0, 3);
          ld_plan.push_back(li);
        end
      end
      start_xfer(d, !d, b, n, 0);
      wait_idle();
    end

    chk("end_queues_empty", 32'(exp_dump.size() + exp_wr.size() + exp_done.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
